crossbar_hs: RTL and testbench
==============================

Name: crossbar_hs

Overview:
- Parametrised IN_N x OUT_N crossbar with valid/ready handshakes and a registered output slot on every output port.
- Unlike the single-path mux/demux crossbar, every output carries its own input select, so any number of disjoint input-to-output paths transfer in the same cycle.
- One input may feed several outputs (all-or-nothing multicast).
- Sits inside a mesh router between the input buffers and the link drivers.
- Selects are driven by the switch allocator.

Parameters:
- DATA_WIDTH, 8, flit width in bits.
- IN_N, 5, number of input ports.
- OUT_N, 5, number of output ports.
- SEL_W, $clog2(IN_N) (derived localparam, not overridable), width of one output's select field.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  IN_N*DATA_WIDTH  packed input flits; port i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- valid_i  input  IN_N  input flit valid, one bit per input.
- ready_o  output  IN_N  input accepted this cycle when valid_i[i] & ready_o[i].
- sel_i  input  OUT_N*SEL_W  packed per-output input index; output j uses bits [SEL_W*(j+1)-1 : SEL_W*j].
- sel_valid_i  input  OUT_N  output j has an active select.
- data_o  output  OUT_N*DATA_WIDTH  packed registered output flits.
- valid_o  output  OUT_N  output slot holds a flit.
- ready_i  input  OUT_N  downstream accepts output j.

Behaviour:
- Reset (async assert, sync deassert by system):
  - valid_o = 0, data_o = 0 on all ports.
  - ready_o is combinational and is 0 whenever sel_valid_i = 0.
- Output j effective select: s_j = sel_i field j, counted only if sel_valid_i[j] & s_j < IN_N. Out-of-range indices count as no select.
- Slot capacity: can_load[j] = !valid_o[j] | ready_i[j].
- Input i status:
  - any_sel[i] = some output effectively selects i.
  - all_ok[i] = every output selecting i has can_load.
- ready_o[i] = any_sel[i] & all_ok[i].
  - Purely combinational from sel_i, sel_valid_i, valid_o and ready_i.
  - Never depends on valid_i, so there is no comb loop with an upstream that waits on ready.
- fire[i] = valid_i[i] & ready_o[i].
- Per output j, each rising edge:
  - If the selected input fires: data_o[j] <= that input's flit, valid_o[j] <= 1.
  - Else if ready_i[j]: valid_o[j] <= 0 and data_o[j] holds.
  - Else: hold.
- Multicast:
  - An input selected by k outputs fires only when all k slots can load.
  - All k slots then load the same flit on the same edge.
  - A partial load is never allowed.
- Latency and throughput:
  - 1 cycle from fire to valid_o.
  - Full throughput of 1 flit/cycle per output when ready_i is held at 1 (drain and load on the same edge).
- Stability: while valid_o[j] & !ready_i[j], data_o[j] is held constant regardless of sel_i or data_i.
- No packet locking: sel_i may change every cycle. Wormhole ownership is the allocator's responsibility.
- Reset asserted mid-transfer: all slots clear immediately and in-flight flits are dropped. Upstream sees no handshake on that edge.

Decomposition:
- Shared header crossbar_defs.vh holds:
  - default DATA_WIDTH and port-count macros;
  - port index constants LOCAL/NORTH/EAST/SOUTH/WEST = 0..4, shared with the router and allocator.
- One natural sub-module, xbar_out_slot, instantiated OUT_N times via generate:
  - one output register slice with its DATA_WIDTH register and valid flag;
  - inputs: load, din, ready_i; outputs: can_load, dout, valid.
- The top level holds:
  - input unpack and per-output input mux;
  - the any_sel / all_ok reduction that builds ready_o.

Test Plan (defaults DATA_WIDTH=8, IN_N=OUT_N=5):
1. Reset: assert rst_i mid-stream with valid_o[3]=1 -> valid_o=0 and data_o=0 asynchronously, before the next edge; ready_o=0 while sel_valid_i=0.
2. Single path: sel out4=2, valid_i[2]=1 with data 0xA5 -> ready_o[2]=1; next cycle valid_o[4]=1 and data_o[4]=0xA5; no other output changes.
3. Parallel paths: in0->out1 (0x11) and in3->out2 (0x33) in the same cycle -> both ready_o=1; next cycle out1=0x11 and out2=0x33. Then stream 8 flits with ready_i=1 -> 8 consecutive valid cycles with no bubbles.
4. Backpressure: out1 holds 0x11 with ready_i[1]=0 and in0 offers 0x22 -> ready_o[0]=0 and data_o[1] stays 0x11 for 3 cycles. Raise ready_i[1] -> ready_o[0]=1 on that same cycle; next cycle data_o[1]=0x22.
5. Multicast: in1 -> out0 and out3, out3 stalled and full -> ready_o[1]=0 and out0 does not load. Release out3 -> both outputs show 0x5C on the same cycle.
6. Invalid select: sel fields of 5, 6 or 7 with sel_valid_i=1 -> no output loads and no ready_o asserted.

Source files
------------

// File: rtl/crossbar_hs_pkg.sv
// Shared crossbar constants: default sizing and mesh port indices.
// Imported by the crossbar, the router and the switch allocator.
package crossbar_hs_pkg;

  localparam int XB_DATA_WIDTH = 8;
  localparam int XB_IN_N       = 5;
  localparam int XB_OUT_N      = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_out_slot.sv
// One registered output slice of the crossbar.
// Loads on request, otherwise drains when downstream is ready.
module xbar_out_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  ready_i,
  output logic                  can_load_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  assign can_load_o = !valid_q | ready_i;
  assign dout_o     = data_q;
  assign valid_o    = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = din_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/crossbar_hs.sv
// IN_N x OUT_N handshaked crossbar, per-output select, all-or-nothing
// multicast, one registered slot per output.
module crossbar_hs
  import crossbar_hs_pkg::*;
#(
  parameter  int DATA_WIDTH = XB_DATA_WIDTH,
  parameter  int IN_N       = XB_IN_N,
  parameter  int OUT_N      = XB_OUT_N,
  localparam int SEL_W      = sel_width(IN_N)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IN_N*DATA_WIDTH-1:0]  data_i,
  input  logic [IN_N-1:0]             valid_i,
  output logic [IN_N-1:0]             ready_o,
  input  logic [OUT_N*SEL_W-1:0]      sel_i,
  input  logic [OUT_N-1:0]            sel_valid_i,
  output logic [OUT_N*DATA_WIDTH-1:0] data_o,
  output logic [OUT_N-1:0]            valid_o,
  input  logic [OUT_N-1:0]            ready_i
);

  localparam logic [SEL_W:0] IN_LIM = (SEL_W+1)'(IN_N);

  logic [DATA_WIDTH-1:0] in_f   [IN_N];
  logic [SEL_W-1:0]      sel_f  [OUT_N];
  logic [DATA_WIDTH-1:0] din_f  [OUT_N];
  logic [DATA_WIDTH-1:0] dout_f [OUT_N];
  logic [OUT_N-1:0]      sel_ok, can_load, load, slot_v;
  logic [IN_N-1:0]       any_sel, all_ok, fire;

  always_comb begin
    for (int i = 0; i < IN_N; i++)
      in_f[i] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
    for (int j = 0; j < OUT_N; j++) begin
      sel_f[j]  = sel_i[j*SEL_W +: SEL_W];
      sel_ok[j] = sel_valid_i[j] & ({1'b0, sel_f[j]} < IN_LIM);
    end
  end

  // ready never looks at valid_i, so upstream may wait on it safely
  always_comb begin
    any_sel = '0;
    all_ok  = '1;
    for (int j = 0; j < OUT_N; j++)
      for (int i = 0; i < IN_N; i++)
        if (sel_ok[j] && sel_f[j] == SEL_W'(i)) begin
          any_sel[i] = 1'b1;
          if (!can_load[j]) all_ok[i] = 1'b0;
        end
  end

  assign ready_o = any_sel & all_ok;
  assign fire    = valid_i & ready_o;

  always_comb begin
    for (int j = 0; j < OUT_N; j++) begin
      load[j]  = 1'b0;
      din_f[j] = '0;
      for (int i = 0; i < IN_N; i++)
        if (sel_ok[j] && sel_f[j] == SEL_W'(i)) begin
          din_f[j] = in_f[i];
          load[j]  = fire[i];
        end
    end
  end

  for (genvar j = 0; j < OUT_N; j++) begin : g_slot
    xbar_out_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load[j]),
      .din_i     (din_f[j]),
      .ready_i   (ready_i[j]),
      .can_load_o(can_load[j]),
      .dout_o    (dout_f[j]),
      .valid_o   (slot_v[j])
    );
    assign data_o[j*DATA_WIDTH +: DATA_WIDTH] = dout_f[j];
  end

  assign valid_o = slot_v;

endmodule

// File: tb/tb_crossbar_hs.sv
// Scoreboard bench for crossbar_hs: directed scenarios plus random traffic.
module tb_crossbar_hs;

  localparam int DW = 8;
  localparam int N  = 5;
  localparam int SW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]  valid_i;
  logic [N-1:0]  ready_o;
  logic [N*SW-1:0] sel_i;
  logic [N-1:0]  sel_valid_i;
  logic [N*DW-1:0] data_o;
  logic [N-1:0]  valid_o;
  logic [N-1:0]  ready_i;

  crossbar_hs dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sel_i      (sel_i),
    .sel_valid_i(sel_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // expected content of each output slot (0 or 1 entries)
  logic [DW-1:0] q [N][$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*SW-1:0] S(input int a0, input int a1,
      input int a2, input int a3, input int a4);
    return {a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
  endfunction

  // monitor: compares slots, retires flits that drain this cycle
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int j = 0; j < N; j++) begin
        chk($sformatf("valid_o[%0d]", j), 64'(valid_o[j]),
            64'(q[j].size() != 0));
        if (q[j].size() != 0) begin
          chk($sformatf("data_o[%0d]", j), 64'(data_o[j*DW +: DW]),
              64'(q[j][0]));
          if (ready_i[j]) void'(q[j].pop_front());
        end
      end
    end
  end

  // reference: a slot can load iff it is empty after this cycle's drain
  task automatic model();
    logic [N-1:0] exp_rdy;
    int s;
    for (int i = 0; i < N; i++) begin
      bit any = 0;
      bit ok  = 1;
      for (int j = 0; j < N; j++) begin
        s = int'(sel_i[j*SW +: SW]);
        if (sel_valid_i[j] && s < N && s == i) begin
          any = 1;
          if (q[j].size() != 0) ok = 0;
        end
      end
      exp_rdy[i] = any & ok;
    end
    chk("ready_o", 64'(ready_o), 64'(exp_rdy));
    for (int j = 0; j < N; j++) begin
      s = int'(sel_i[j*SW +: SW]);
      if (sel_valid_i[j] && s < N && exp_rdy[s] && valid_i[s])
        q[j].push_back(data_i[s*DW +: DW]);
    end
  endtask

  task automatic step(input logic [N*SW-1:0] s, input logic [N-1:0] sv,
      input logic [N-1:0] vi, input logic [N*DW-1:0] d,
      input logic [N-1:0] r);
    @(posedge clk_i);
    #1;
    sel_i       = s;
    sel_valid_i = sv;
    valid_i     = vi;
    data_i      = d;
    ready_i     = r;
    @(negedge clk_i);
    #1;
    model();
  endtask

  task automatic reset_mid();
    @(negedge clk_i);
    #2;
    sel_valid_i = '0;
    valid_i     = '0;
    rst_i       = 1'b1;
    #1;
    chk("rst valid_o", 64'(valid_o), 64'(0));
    chk("rst data_o", 64'(data_o), 64'(0));
    chk("rst ready_o", 64'(ready_o), 64'(0));
    for (int j = 0; j < N; j++) q[j].delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    data_i      = '0;
    valid_i     = '0;
    sel_i       = '0;
    sel_valid_i = '0;
    ready_i     = '0;
    #2;
    chk("init valid_o", 64'(valid_o), 64'(0));
    chk("init data_o", 64'(data_o), 64'(0));
    chk("init ready_o", 64'(ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // single path in2 -> out4
    step(S(0,0,0,0,2), 5'b10000, 5'b00100, 40'hA5 << 16, 5'b00000);
    step('0, 5'b00000, 5'b00000, '0, 5'b11111);

    // parallel in0 -> out1, in3 -> out2
    step(S(0,0,3,0,0), 5'b00110, 5'b01001, 40'h0033000011, 5'b11111);
    for (int k = 0; k < 8; k++)
      step(S(0,0,0,0,0), 5'b00010, 5'b00001, 40'(8'h40 + k), 5'b11111);
    step('0, 5'b00000, 5'b00000, '0, 5'b11111);

    // backpressure on out1
    step(S(0,0,0,0,0), 5'b00010, 5'b00001, 40'h11, 5'b00000);
    for (int k = 0; k < 3; k++)
      step(S(0,0,0,0,0), 5'b00010, 5'b00001, 40'h22, 5'b00000);
    step(S(0,0,0,0,0), 5'b00010, 5'b00001, 40'h22, 5'b00010);
    step('0, 5'b00000, 5'b00000, '0, 5'b11111);

    // multicast in1 -> out0 + out3 with out3 stalled
    step(S(0,0,0,1,0), 5'b01000, 5'b00010, 40'hAA << 8, 5'b00000);
    step(S(1,0,0,1,0), 5'b01001, 5'b00010, 40'h5C << 8, 5'b00000);
    step(S(1,0,0,1,0), 5'b01001, 5'b00010, 40'h5C << 8, 5'b00000);
    step(S(1,0,0,1,0), 5'b01001, 5'b00010, 40'h5C << 8, 5'b01000);
    step('0, 5'b00000, 5'b00000, '0, 5'b00000);

    // reset while out0/out3 hold data
    reset_mid();

    // out-of-range selects
    step(S(5,6,7,5,6), 5'b11111, 5'b11111, 40'h0102030405, 5'b11111);
    step(S(7,7,6,6,5), 5'b11111, 5'b11111, 40'h1112131415, 5'b11111);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(S($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7),
             $urandom_range(0,7), $urandom_range(0,7)),
           5'($urandom), 5'($urandom),
           {8'($urandom), 32'($urandom)}, 5'($urandom));
    step('0, 5'b00000, 5'b00000, '0, 5'b11111);
    step('0, 5'b00000, 5'b00000, '0, 5'b11111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
